// File: rtl/branch_resolve_queue.sv
// In-order record of fetched conditional branches between IF and EXE.
// Resolves them against their predictions and drives the predictor update.
module branch_resolve_queue #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     if_br0_valid,
  input  logic [PC_W-1:0]          if_br0_pc,
  input  logic                     if_br0_pred_taken,
  input  logic                     if_br1_valid,
  input  logic [PC_W-1:0]          if_br1_pc,
  input  logic                     if_br1_pred_taken,
  output logic                     enq_ready,
  input  logic                     exe_resolve_valid,
  input  logic [PC_W-1:0]          exe_resolve_pc,
  input  logic                     exe_resolve_taken,
  input  logic                     pipe_flush,
  output logic                     exe_cond_valid,
  output logic                     exe_cond_miss_prediction,
  output logic                     exe_cond_branch_taken,
  output logic [PC_W-1:0]          exe_cond_branch_addr,
  output logic                     order_error,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W-1:0] r_pc [DEPTH];
  logic            r_pt [DEPTH];
  logic [AW-1:0]   r_head;
  logic [AW-1:0]   r_tail;
  logic [CW-1:0]   r_count;
  logic            r_err;
  logic            r_cv;
  logic            r_miss;
  logic            r_tk;
  logic [PC_W-1:0] r_addr;

  logic            w_empty;
  logic            w_pop;
  logic            w_miss;
  logic            w_recover;
  logic            w_pc_bad;
  logic            w_push0;
  logic            w_push1;
  logic [1:0]      w_npush;
  logic [AW-1:0]   w_slot1;
  logic            w_wr_en;

  assign enq_ready = (CW'(DEPTH) - r_count) >= CW'(2);

  assign w_empty   = (r_count == '0);
  assign w_pop     = exe_resolve_valid & ~w_empty;
  assign w_miss    = exe_resolve_taken ^ r_pt[r_head];
  assign w_recover = w_pop & w_miss;
  assign w_pc_bad  = w_pop & (exe_resolve_pc != r_pc[r_head]);
  assign w_push0   = if_br0_valid & enq_ready;
  assign w_push1   = if_br1_valid & enq_ready;
  assign w_npush   = {1'b0, w_push0} + {1'b0, w_push1};
  assign w_slot1   = r_tail + AW'(w_push0);
  // Wrong-path and flushed pushes must never land in storage.
  assign w_wr_en   = rst & ~pipe_flush & ~w_recover;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      if (w_push0) begin
        r_pc[r_tail] <= if_br0_pc;
        r_pt[r_tail] <= if_br0_pred_taken;
      end
      if (w_push1) begin
        r_pc[w_slot1] <= if_br1_pc;
        r_pt[w_slot1] <= if_br1_pred_taken;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
      r_cv    <= 1'b0;
      r_miss  <= 1'b0;
      r_tk    <= 1'b0;
      r_addr  <= '0;
    end else begin
      r_cv   <= 1'b0;
      r_miss <= 1'b0;
      r_tk   <= 1'b0;
      r_addr <= '0;
      if (pipe_flush) begin
        r_count <= '0;
        r_tail  <= r_head;
      end else begin
        if ((exe_resolve_valid & w_empty) | w_pc_bad)
          r_err <= 1'b1;
        if (w_pop) begin
          r_cv   <= 1'b1;
          r_miss <= w_miss;
          r_tk   <= exe_resolve_taken;
          r_addr <= exe_resolve_pc;
        end
        if (w_recover) begin
          r_head  <= r_head + AW'(1);
          r_tail  <= r_head + AW'(1);
          r_count <= '0;
        end else begin
          r_head  <= r_head + AW'(w_pop);
          r_tail  <= r_tail + AW'(w_npush);
          r_count <= r_count - CW'(w_pop) + CW'(w_npush);
        end
      end
    end
  end

  assign exe_cond_valid           = r_cv;
  assign exe_cond_miss_prediction = r_miss;
  assign exe_cond_branch_taken    = r_tk;
  assign exe_cond_branch_addr     = r_addr;
  assign order_error              = r_err;
  assign occupancy                = r_count;

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_branch_resolve_queue;

  localparam int DEPTH = 8;
  localparam int PC_W  = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            b0v, b0t, b1v, b1t;
  logic [PC_W-1:0] b0pc, b1pc;
  logic            enq_ready;
  logic            rv, rt, fl;
  logic [PC_W-1:0] rpc;
  logic            cv, cmiss, ctk;
  logic [PC_W-1:0] caddr;
  logic            oerr;
  logic [3:0]      occ;

  int vec = 0;
  int errs = 0;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            pt;
  } ent_t;

  ent_t            mq[$];
  bit              m_err;
  bit              m_v, m_miss, m_tk;
  logic [PC_W-1:0] m_addr;

  branch_resolve_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst),
    .if_br0_valid(b0v), .if_br0_pc(b0pc), .if_br0_pred_taken(b0t),
    .if_br1_valid(b1v), .if_br1_pc(b1pc), .if_br1_pred_taken(b1t),
    .enq_ready(enq_ready),
    .exe_resolve_valid(rv), .exe_resolve_pc(rpc),
    .exe_resolve_taken(rt), .pipe_flush(fl),
    .exe_cond_valid(cv), .exe_cond_miss_prediction(cmiss),
    .exe_cond_branch_taken(ctk), .exe_cond_branch_addr(caddr),
    .order_error(oerr), .occupancy(occ)
  );

  always #5 clk = ~clk;

  // Reference: a plain queue of outstanding branches, updated by priority.
  task automatic model_step();
    int   n;
    bit   rdy;
    ent_t h;
    n = mq.size();
    rdy = (DEPTH - n) >= 2;
    m_v = 0; m_miss = 0; m_tk = 0; m_addr = '0;
    if (!rst) begin
      mq.delete();
      m_err = 0;
      return;
    end
    if (fl) begin
      mq.delete();
      return;
    end
    if (rv) begin
      if (n == 0) m_err = 1;
      else begin
        h = mq.pop_front();
        if (h.pc != rpc) m_err = 1;
        m_v = 1; m_tk = rt; m_addr = rpc;
        m_miss = (rt != h.pt);
        if (m_miss) begin
          mq.delete();
          return;
        end
      end
    end
    if (rdy) begin
      if (b0v) mq.push_back('{pc: b0pc, pt: b0t});
      if (b1v) mq.push_back('{pc: b1pc, pt: b1t});
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    b0v = 0; b0t = 0; b0pc = '0;
    b1v = 0; b1t = 0; b1pc = '0;
    rv = 0; rt = 0; rpc = '0; fl = 0;
  endtask

  task automatic push2(input logic [PC_W-1:0] p0, input logic t0,
                       input logic [PC_W-1:0] p1, input logic t1);
    idle();
    b0v = 1; b0pc = p0; b0t = t0;
    b1v = 1; b1pc = p1; b1t = t1;
    cycle();
    idle();
  endtask

  task automatic resolve(input logic [PC_W-1:0] p, input logic t);
    idle();
    rv = 1; rpc = p; rt = t;
    cycle();
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst = 0;
    cycle();
    rst = 1;
  endtask

  task automatic test_reset();
    do_reset();
    vec++;
    if ({cv, cmiss, ctk, caddr, oerr, occ} !== '0 || enq_ready !== 1'b1) begin
      errs++;
      $display("FAIL reset cv=%b miss=%b tk=%b addr=%h err=%b occ=%0d rdy=%b want zeros, rdy=1",
               cv, cmiss, ctk, caddr, oerr, occ, enq_ready);
    end
  endtask

  task automatic test_basic();
    push2(32'h1000, 1'b1, 32'h1004, 1'b0);
    vec++;
    if (occ !== 4'd2) begin
      errs++; $display("FAIL basic_occ got %0d want 2", occ);
    end
    resolve(32'h1000, 1'b1);
    vec++;
    if ({cv, cmiss, ctk} !== 3'b101 || caddr !== 32'h1000 || occ !== 4'd1) begin
      errs++;
      $display("FAIL basic_hit v/miss/tk=%b%b%b addr=%h occ=%0d want 101 1000 1",
               cv, cmiss, ctk, caddr, occ);
    end
    resolve(32'h1004, 1'b1);
    vec++;
    if ({cv, cmiss, ctk} !== 3'b111 || caddr !== 32'h1004 || occ !== 4'd0) begin
      errs++;
      $display("FAIL basic_miss v/miss/tk=%b%b%b addr=%h occ=%0d want 111 1004 0",
               cv, cmiss, ctk, caddr, occ);
    end
    cycle();
    vec++;
    if ({cv, cmiss, ctk, caddr} !== '0) begin
      errs++; $display("FAIL pulse_width cv=%b addr=%h want 0", cv, caddr);
    end
  endtask

  task automatic test_mispredict_discard();
    do_reset();
    push2(32'h2000, 1'b1, 32'h2004, 1'b1);
    push2(32'h2008, 1'b1, 32'h200C, 1'b1);
    vec++;
    if (occ !== 4'd4) begin
      errs++; $display("FAIL mp_fill occ got %0d want 4", occ);
    end
    idle();
    rv = 1; rpc = 32'h2000; rt = 0;
    b0v = 1; b0pc = 32'h3000; b0t = 1;
    cycle();
    idle();
    vec++;
    if ({cv, cmiss, ctk} !== 3'b110 || occ !== 4'd0) begin
      errs++;
      $display("FAIL mp_discard v/miss/tk=%b%b%b occ=%0d want 110 0", cv, cmiss, ctk, occ);
    end
    push2(32'h5000, 1'b0, 32'h5004, 1'b1);
    resolve(32'h5000, 1'b0);
    vec++;
    if (oerr !== 1'b0 || cv !== 1'b1 || cmiss !== 1'b0 || occ !== 4'd1) begin
      errs++;
      $display("FAIL mp_realign err=%b cv=%b miss=%b occ=%0d want 0 1 0 1", oerr, cv, cmiss, occ);
    end
  endtask

  task automatic test_full_and_wrap();
    logic [PC_W-1:0] base;
    logic            pr [6];
    do_reset();
    push2(32'h6000, 1'b1, 32'h6004, 1'b1);
    push2(32'h6008, 1'b1, 32'h600C, 1'b1);
    push2(32'h6010, 1'b1, 32'h6014, 1'b1);
    idle(); b0v = 1; b0pc = 32'h6018; b0t = 1; cycle(); idle();
    vec++;
    if (occ !== 4'd7 || enq_ready !== 1'b0) begin
      errs++; $display("FAIL full occ=%0d rdy=%b want 7 0", occ, enq_ready);
    end
    push2(32'h6020, 1'b0, 32'h6024, 1'b0);
    vec++;
    if (occ !== 4'd7) begin
      errs++; $display("FAIL drop occ got %0d want 7", occ);
    end
    resolve(32'h6000, 1'b1);
    vec++;
    if (occ !== 4'd6 || enq_ready !== 1'b1 || cmiss !== 1'b0) begin
      errs++;
      $display("FAIL unfull occ=%0d rdy=%b miss=%b want 6 1 0", occ, enq_ready, cmiss);
    end
    for (int k = 1; k < 7; k++) resolve(32'h6000 + 32'(4 * k), 1'b1);
    vec++;
    if (occ !== 4'd0 || oerr !== 1'b0) begin
      errs++; $display("FAIL drain occ=%0d err=%b want 0 0", occ, oerr);
    end
    for (int r = 0; r < 3; r++) begin
      base = 32'h8000 + 32'(r * 32'h100);
      for (int k = 0; k < 6; k++) pr[k] = 1'($urandom_range(0, 1));
      for (int k = 0; k < 6; k += 2)
        push2(base + 32'(4 * k), pr[k], base + 32'(4 * k + 4), pr[k + 1]);
      for (int k = 0; k < 6; k++) begin
        resolve(base + 32'(4 * k), pr[k]);
        vec++;
        if (cv !== 1'b1 || cmiss !== 1'b0 || caddr !== base + 32'(4 * k) || oerr !== 1'b0) begin
          errs++;
          $display("FAIL wrap r%0d k%0d cv=%b miss=%b addr=%h err=%b want 1 0 %h 0",
                   r, k, cv, cmiss, caddr, oerr, base + 32'(4 * k));
        end
      end
    end
  endtask

  task automatic test_random();
    bit push_ok;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      idle();
      push_ok = (DEPTH - mq.size()) >= 2;
      if (push_ok && $urandom_range(0, 2) != 0) begin
        b0v = 1'($urandom_range(0, 1));
        b1v = 1'($urandom_range(0, 1));
        b0pc = {$urandom_range(0, 32'hFFFF), 2'b00};
        b1pc = b0pc + 32'd4;
        b0t = 1'($urandom_range(0, 1));
        b1t = 1'($urandom_range(0, 1));
      end
      if (mq.size() > 0 && $urandom_range(0, 1) == 1) begin
        rv = 1; rpc = mq[0].pc;
        rt = ($urandom_range(0, 3) == 0) ? ~mq[0].pt : mq[0].pt;
      end
      fl = ($urandom_range(0, 19) == 0);
      cycle();
      vec++;
      if (cv !== m_v || cmiss !== m_miss || ctk !== m_tk || caddr !== m_addr) begin
        errs++;
        $display("FAIL rand_upd c%0d got %b%b%b %h want %b%b%b %h",
                 c, cv, cmiss, ctk, caddr, m_v, m_miss, m_tk, m_addr);
      end
      vec++;
      if (occ !== 4'(mq.size()) || enq_ready !== ((DEPTH - mq.size()) >= 2) || oerr !== m_err) begin
        errs++;
        $display("FAIL rand_state c%0d occ=%0d rdy=%b err=%b want %0d %b %b",
                 c, occ, enq_ready, oerr, mq.size(), (DEPTH - mq.size()) >= 2, m_err);
      end
    end
    idle();
  endtask

  task automatic test_order_error();
    do_reset();
    resolve(32'h1234, 1'b1);
    vec++;
    if (oerr !== 1'b1 || cv !== 1'b0 || occ !== 4'd0) begin
      errs++; $display("FAIL empty_resolve err=%b cv=%b occ=%0d want 1 0 0", oerr, cv, occ);
    end
    do_reset();
    idle(); b0v = 1; b0pc = 32'h4000; b0t = 1; cycle(); idle();
    resolve(32'h4008, 1'b1);
    vec++;
    if (oerr !== 1'b1 || cv !== 1'b1 || caddr !== 32'h4008 || cmiss !== 1'b0) begin
      errs++;
      $display("FAIL pc_mismatch err=%b cv=%b addr=%h miss=%b want 1 1 4008 0", oerr, cv, caddr, cmiss);
    end
    cycle();
    vec++;
    if (oerr !== 1'b1) begin
      errs++; $display("FAIL sticky err=%b want 1", oerr);
    end
  endtask

  task automatic test_flush_and_reset();
    do_reset();
    push2(32'h7000, 1'b1, 32'h7004, 1'b1);
    push2(32'h7008, 1'b0, 32'h700C, 1'b0);
    idle(); b0v = 1; b0pc = 32'h7010; b0t = 1; cycle(); idle();
    vec++;
    if (occ !== 4'd5) begin
      errs++; $display("FAIL fl_fill occ got %0d want 5", occ);
    end
    idle(); fl = 1; rv = 1; rpc = 32'h7000; rt = 1; cycle(); idle();
    vec++;
    if (occ !== 4'd0 || cv !== 1'b0 || oerr !== 1'b0) begin
      errs++; $display("FAIL flush occ=%0d cv=%b err=%b want 0 0 0", occ, cv, oerr);
    end
    cycle();
    vec++;
    if (cv !== 1'b0 || occ !== 4'd0) begin
      errs++; $display("FAIL flush_after cv=%b occ=%0d want 0 0", cv, occ);
    end
    resolve(32'h0, 1'b0);
    push2(32'h7100, 1'b1, 32'h7104, 1'b0);
    idle(); rv = 1; rpc = 32'h7100; rt = 1;
    b0v = 1; b0pc = 32'h7200; b0t = 1; b1v = 1; b1pc = 32'h7204;
    rst = 0;
    cycle();
    rst = 1;
    idle();
    vec++;
    if ({cv, cmiss, ctk, caddr, oerr, occ} !== '0 || enq_ready !== 1'b1) begin
      errs++;
      $display("FAIL mid_reset cv=%b err=%b occ=%0d rdy=%b addr=%h want 0 0 0 1 0",
               cv, oerr, occ, enq_ready, caddr);
    end
  endtask

  initial begin
    idle();
    rst = 0;
    test_reset();
    test_basic();
    test_mispredict_discard();
    test_full_and_wrap();
    test_random();
    test_order_error();
    test_flush_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
